// File: rtl/dtw_multi_ctrl.sv
// Register-mapped controller for up to eight DTW cores: global ID/IRQ registers plus per-core control FSMs.
// Latency: register write/read strobes answer one cycle after the request; o_irq follows IRQ state by one cycle.
// Backpressure: one request per strobe cycle; new requests are not accepted while ack or read strobe is high.
module dtw_multi_ctrl #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_CORES     = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           i_reg_address,
  input  logic                            i_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0]           i_reg_in_data,
  output logic                            o_reg_in_ack_stb,
  input  logic                            i_reg_out_req,
  output logic                            o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]           o_reg_out_data,
  output logic                            o_reg_invalid_addr,
  output logic [NUM_CORES-1:0]            o_core_rst,
  output logic [NUM_CORES-1:0]            o_core_rs,
  output logic [NUM_CORES-1:0]            o_core_mode,
  output logic [NUM_CORES*DATA_WIDTH-1:0] o_ref_len,
  input  logic [NUM_CORES-1:0]            i_core_busy,
  input  logic [NUM_CORES-1:0]            i_core_load_done,
  output logic                            o_irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0]    VERSION  = DATA_WIDTH'(32'h2000_0000);
  localparam logic [DATA_WIDTH-1:0]    KEY      = DATA_WIDTH'(32'h0ca7_cafe);
  // Last ARMED count value before giving up; the FSM leaves ARMED on the edge that would reach all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  localparam int                       HI_W     = ADDR_WIDTH - 4;

  // Bus handshake state
  logic                  ack_q, rdy_q, inv_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  acc_wr, acc_rd;

  // Global registers
  logic [NUM_CORES-1:0]  irq_en_q, irq_st_q, irq_st_d;
  logic                  irq_q;

  // Per-core registers
  state_t                state_q [NUM_CORES];
  state_t                state_d [NUM_CORES];
  logic [DATA_WIDTH-1:0] ref_len_q [NUM_CORES];
  logic [DATA_WIDTH-1:0] cycles_q [NUM_CORES];
  logic [TIMEOUT_WIDTH-1:0] tmo_q [NUM_CORES];
  logic [NUM_CORES-1:0]  core_rst_q, mode_q, done_q, tout_q;
  logic [NUM_CORES-1:0]  done_evt, tout_evt, start_w;

  // Address decode outputs
  logic                  is_glob, is_core, addr_ok;
  logic [HI_W-1:0]       core_hi;
  logic [3:0]            g_sel;
  logic [1:0]            reg_sel;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  we_irq_en, we_irq_clr;
  logic [NUM_CORES-1:0]  we_ctrl, we_ref;

  // A request is only taken while neither strobe is up; a write wins over a read.
  assign acc_wr = i_reg_in_rdy & ~ack_q & ~rdy_q;
  assign acc_rd = i_reg_out_req & ~i_reg_in_rdy & ~ack_q & ~rdy_q;

  assign g_sel   = i_reg_address[5:2];
  assign reg_sel = i_reg_address[3:2];
  assign core_hi = i_reg_address[ADDR_WIDTH-1:4] - HI_W'(4);
  assign is_glob = (i_reg_address[ADDR_WIDTH-1:6] == '0) && (i_reg_address[1:0] == 2'b00);
  assign is_core = (i_reg_address[ADDR_WIDTH-1:4] >= HI_W'(4)) && (core_hi < HI_W'(NUM_CORES))
                   && (i_reg_address[1:0] == 2'b00);

  // Address decode: read mux and per-register write enables (enables only fire on an accepted write).
  always_comb begin
    addr_ok    = 1'b0;
    rd_val     = '0;
    we_irq_en  = 1'b0;
    we_irq_clr = 1'b0;
    we_ctrl    = '0;
    we_ref     = '0;
    if (is_glob) begin
      addr_ok = 1'b1;
      case (g_sel)
        4'd0: rd_val = VERSION;
        4'd1: rd_val = KEY;
        4'd2: begin rd_val = DATA_WIDTH'(irq_en_q); we_irq_en  = acc_wr; end
        4'd3: begin rd_val = DATA_WIDTH'(irq_st_q); we_irq_clr = acc_wr; end
        4'd4: rd_val = DATA_WIDTH'(NUM_CORES);
        default: addr_ok = 1'b0;
      endcase
    end else if (is_core) begin
      addr_ok = 1'b1;
      for (int n = 0; n < NUM_CORES; n++) begin
        if (core_hi == HI_W'(n)) begin
          case (reg_sel)
            2'd0: begin
              rd_val     = {{(DATA_WIDTH-3){1'b0}}, mode_q[n], 1'b0, core_rst_q[n]};
              we_ctrl[n] = acc_wr;
            end
            2'd1: rd_val = {{(DATA_WIDTH-6){1'b0}}, state_q[n], tout_q[n], done_q[n],
                            i_core_load_done[n], i_core_busy[n]};
            2'd2: begin
              rd_val    = ref_len_q[n];
              we_ref[n] = acc_wr;
            end
            default: rd_val = cycles_q[n];
          endcase
        end
      end
    end
  end

  // Per-core FSM next state; abort and core reset override everything and never raise an event.
  always_comb begin
    done_evt = '0;
    tout_evt = '0;
    start_w  = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      state_d[n] = state_q[n];
      start_w[n] = we_ctrl[n] & i_reg_in_data[1];
      if ((we_ctrl[n] & (i_reg_in_data[3] | i_reg_in_data[0])) | core_rst_q[n]) begin
        state_d[n] = ST_IDLE;
      end else begin
        case (state_q[n])
          ST_IDLE: if (start_w[n]) state_d[n] = ST_ARMED;
          ST_ARMED: begin
            if (i_core_busy[n]) begin
              state_d[n] = ST_RUN;
            end else if (tmo_q[n] == TMO_LAST) begin
              state_d[n]  = ST_IDLE;
              tout_evt[n] = 1'b1;
            end
          end
          ST_RUN: begin
            if (!i_core_busy[n]) begin
              state_d[n]  = ST_IDLE;
              done_evt[n] = 1'b1;
            end
          end
          default: state_d[n] = ST_IDLE;
        endcase
      end
    end
    // A new event on a bit beats a coincident write-1-to-clear of that bit.
    irq_st_d = (irq_st_q & ~(we_irq_clr ? i_reg_in_data[NUM_CORES-1:0] : '0)) | done_evt | tout_evt;
  end

  // Bus strobes, read data register and global registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      inv_q    <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= '0;
      irq_st_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= acc_wr;
      rdy_q    <= acc_rd;
      inv_q    <= (acc_wr | acc_rd) & ~addr_ok;
      if (acc_rd) rdata_q <= rd_val;
      if (we_irq_en) irq_en_q <= i_reg_in_data[NUM_CORES-1:0];
      irq_st_q <= irq_st_d;
      irq_q    <= |(irq_st_q & irq_en_q);
    end
  end

  // Per-core state, control bits, stickies and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_q <= '0;
      mode_q     <= '0;
      done_q     <= '0;
      tout_q     <= '0;
      for (int n = 0; n < NUM_CORES; n++) begin
        state_q[n]   <= ST_IDLE;
        ref_len_q[n] <= '0;
        cycles_q[n]  <= '0;
        tmo_q[n]     <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CORES; n++) begin
        state_q[n] <= state_d[n];
        if (we_ctrl[n]) begin
          core_rst_q[n] <= i_reg_in_data[0];
          mode_q[n]     <= i_reg_in_data[2];
        end
        if (we_ref[n]) ref_len_q[n] <= i_reg_in_data;
        if (start_w[n]) begin
          done_q[n] <= 1'b0;
          tout_q[n] <= 1'b0;
        end
        if (done_evt[n]) done_q[n] <= 1'b1;
        if (tout_evt[n]) tout_q[n] <= 1'b1;
        if (state_q[n] == ST_IDLE && state_d[n] == ST_ARMED) begin
          tmo_q[n]    <= '0;
          cycles_q[n] <= '0;
        end else begin
          if (state_q[n] == ST_ARMED) tmo_q[n] <= tmo_q[n] + TIMEOUT_WIDTH'(1);
          if (state_q[n] == ST_RUN && cycles_q[n] != '1) cycles_q[n] <= cycles_q[n] + DATA_WIDTH'(1);
        end
      end
    end
  end

  // Core-facing outputs derived from stored state.
  always_comb begin
    for (int n = 0; n < NUM_CORES; n++) begin
      o_core_rs[n]                         = (state_q[n] == ST_ARMED) || (state_q[n] == ST_RUN);
      o_ref_len[n*DATA_WIDTH +: DATA_WIDTH] = ref_len_q[n];
    end
  end

  assign o_core_rst         = core_rst_q;
  assign o_core_mode        = mode_q;
  assign o_reg_in_ack_stb   = ack_q;
  assign o_reg_out_rdy_stb  = rdy_q;
  assign o_reg_out_data     = rdata_q;
  assign o_reg_invalid_addr = inv_q;
  assign o_irq              = irq_q;

endmodule

// File: tb/tb_dtw_multi_ctrl.sv
// Self-checking bench for dtw_multi_ctrl: register map table, core run/timeout/abort sequences, randomized register traffic.
module tb_dtw_multi_ctrl;

  logic         clk, rst;
  logic [15:0]  reg_address;
  logic         reg_in_rdy, reg_out_req;
  logic [31:0]  reg_in_data;
  logic         ack, out_rdy, inv;
  logic [31:0]  out_data;
  logic [3:0]   core_rst, core_rs, core_mode, core_busy, core_load_done;
  logic [127:0] ref_len;
  logic         irq;

  int errors = 0;
  int checks = 0;

  dtw_multi_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_CORES(4), .TIMEOUT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_reg_address(reg_address), .i_reg_in_rdy(reg_in_rdy), .i_reg_in_data(reg_in_data),
    .o_reg_in_ack_stb(ack), .i_reg_out_req(reg_out_req), .o_reg_out_rdy_stb(out_rdy),
    .o_reg_out_data(out_data), .o_reg_invalid_addr(inv),
    .o_core_rst(core_rst), .o_core_rs(core_rs), .o_core_mode(core_mode), .o_ref_len(ref_len),
    .i_core_busy(core_busy), .i_core_load_done(core_load_done), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic exp_inv);
    reg_address = a; reg_in_data = d; reg_in_rdy = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("wr_ack@%h", a), 32'(ack), 1);
    chk($sformatf("wr_inv@%h", a), 32'(inv), 32'(exp_inv));
    reg_in_rdy = 1'b0;
    @(posedge clk); #1;
    chk("wr_ack_one_cycle", 32'(ack), 0);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic iv);
    reg_address = a; reg_out_req = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("rd_stb@%h", a), 32'(out_rdy), 1);
    d = out_data; iv = inv;
    reg_out_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_stb_one_cycle", 32'(out_rdy), 0);
  endtask

  task automatic read_chk(input string nm, input logic [15:0] a, input logic [31:0] exp_d, input logic exp_inv);
    logic [31:0] d;
    logic        iv;
    bus_read(a, d, iv);
    chk(nm, d, exp_d);
    chk({nm, "_inv"}, 32'(iv), 32'(exp_inv));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] exp_d;
    logic        exp_inv;
  } rvec_t;

  rvec_t tbl[13];

  // Behavioural model of the read/write registers, indexed by core number.
  logic [31:0] ref_m [4];
  logic [3:0]  irq_en_m;

  initial begin
    tbl[0]  = '{16'h0000, 32'h2000_0000, 1'b0};
    tbl[1]  = '{16'h0004, 32'h0ca7_cafe, 1'b0};
    tbl[2]  = '{16'h0008, 32'h0,         1'b0};
    tbl[3]  = '{16'h000C, 32'h0,         1'b0};
    tbl[4]  = '{16'h0010, 32'd4,         1'b0};
    tbl[5]  = '{16'h0014, 32'h0,         1'b1};
    tbl[6]  = '{16'h0002, 32'h0,         1'b1};
    tbl[7]  = '{16'h003C, 32'h0,         1'b1};
    tbl[8]  = '{16'h0040, 32'h0,         1'b0};
    tbl[9]  = '{16'h0044, 32'h0,         1'b0};
    tbl[10] = '{16'h007C, 32'h0,         1'b0};
    tbl[11] = '{16'h0080, 32'h0,         1'b1};
    tbl[12] = '{16'hFFFC, 32'h0,         1'b1};

    rst = 1'b1; reg_address = '0; reg_in_rdy = 1'b0; reg_out_req = 1'b0; reg_in_data = '0;
    core_busy = '0; core_load_done = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of all outputs
    chk("rst_core_rs", 32'(core_rs), 0);
    chk("rst_core_rst", 32'(core_rst), 0);
    chk("rst_core_mode", 32'(core_mode), 0);
    chk("rst_ref_len_or", 32'(|ref_len), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_strobes", {29'd0, ack, out_rdy, inv}, 0);
    chk("rst_out_data", out_data, 0);

    // Register map table
    for (int i = 0; i < 13; i++)
      read_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp_d, tbl[i].exp_inv);

    // Write to a read-only register, then to an unmapped one
    bus_write(16'h0004, 32'h1234_5678, 1'b0);
    read_chk("key_after_wr", 16'h0004, 32'h0ca7_cafe, 1'b0);
    bus_write(16'h0080, 32'hFFFF_FFFF, 1'b1);

    // Simultaneous write and read: write goes first, read returns the new value
    reg_address = 16'h0008; reg_in_data = 32'h2; reg_in_rdy = 1'b1; reg_out_req = 1'b1;
    @(posedge clk); #1;
    chk("sim_ack", 32'(ack), 1);
    chk("sim_no_rdy", 32'(out_rdy), 0);
    reg_in_rdy = 1'b0;
    @(posedge clk); #1;
    chk("sim_blocked", {30'd0, ack, out_rdy}, 0);
    @(posedge clk); #1;
    chk("sim_rdy", 32'(out_rdy), 1);
    chk("sim_data", out_data, 32'h2);
    reg_out_req = 1'b0;
    @(posedge clk); #1;
    irq_en_m = 4'h2;

    // Core1 full run with IRQ enabled
    core_load_done[1] = 1'b1;
    bus_write(16'h0058, 32'h123, 1'b0);
    chk("c1_ref_len_port", ref_len[63:32], 32'h123);
    bus_write(16'h0050, 32'h6, 1'b0);
    chk("c1_rs_armed", 32'(core_rs), 32'h2);
    chk("c1_mode", 32'(core_mode), 32'h2);
    read_chk("c1_status_armed", 16'h0054, 32'h12, 1'b0);
    read_chk("c1_control", 16'h0050, 32'h4, 1'b0);
    core_busy[1] = 1'b1;
    @(posedge clk); #1;
    chk("c1_rs_run", 32'(core_rs[1]), 1);
    repeat (9) @(posedge clk);
    #1 core_busy[1] = 1'b0;
    @(posedge clk); #1;
    chk("c1_rs_idle", 32'(core_rs[1]), 0);
    chk("c1_irq_lag", 32'(irq), 0);
    @(posedge clk); #1;
    chk("c1_irq", 32'(irq), 1);
    read_chk("c1_cycles", 16'h005C, 32'd10, 1'b0);
    read_chk("c1_status_done", 16'h0054, 32'h6, 1'b0);
    read_chk("c1_irq_status", 16'h000C, 32'h2, 1'b0);
    bus_write(16'h000C, 32'h2, 1'b0);
    chk("c1_irq_cleared", 32'(irq), 0);

    // Core0 start timeout (TIMEOUT_WIDTH=4 gives 15 ARMED cycles)
    bus_write(16'h0040, 32'h2, 1'b0);
    repeat (13) @(posedge clk);
    #1 chk("c0_armed_14", 32'(core_rs[0]), 1);
    @(posedge clk); #1;
    chk("c0_timed_out", 32'(core_rs[0]), 0);
    read_chk("c0_status_tout", 16'h0044, 32'h8, 1'b0);
    read_chk("c0_cycles", 16'h004C, 32'h0, 1'b0);
    read_chk("c0_irq_status", 16'h000C, 32'h1, 1'b0);
    chk("c0_irq_masked", 32'(irq), 0);
    bus_write(16'h000C, 32'h1, 1'b0);

    // W1C on bit2 in the same cycle core2 completes
    bus_write(16'h0060, 32'h2, 1'b0);
    core_busy[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 core_busy[2] = 1'b0;
    bus_write(16'h000C, 32'h4, 1'b0);
    read_chk("c2_w1c_race", 16'h000C, 32'h4, 1'b0);
    bus_write(16'h000C, 32'h4, 1'b0);
    read_chk("c2_w1c_clear", 16'h000C, 32'h0, 1'b0);

    // Abort during RUN on core3
    bus_write(16'h0008, 32'hF, 1'b0);
    irq_en_m = 4'hF;
    bus_write(16'h0070, 32'h2, 1'b0);
    core_busy[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("c3_running", 32'(core_rs[3]), 1);
    bus_write(16'h0070, 32'h8, 1'b0);
    chk("c3_aborted", 32'(core_rs[3]), 0);
    core_busy[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("c3_no_irq", 32'(irq), 0);
    read_chk("c3_irq_status", 16'h000C, 32'h0, 1'b0);
    read_chk("c3_status", 16'h0074, 32'h0, 1'b0);

    // Start ignored while core reset is held
    bus_write(16'h0070, 32'h1, 1'b0);
    chk("c3_core_rst", 32'(core_rst), 32'h8);
    bus_write(16'h0070, 32'h3, 1'b0);
    chk("c3_start_ignored", 32'(core_rs[3]), 0);
    read_chk("c3_ctrl_rst", 16'h0070, 32'h1, 1'b0);
    bus_write(16'h0070, 32'h0, 1'b0);
    chk("c3_core_rst_off", 32'(core_rst), 0);

    // Randomized register traffic against the model
    ref_m[0] = 32'h0; ref_m[1] = 32'h123; ref_m[2] = 32'h0; ref_m[3] = 32'h0;
    for (int it = 0; it < 40; it++) begin
      int op, c;
      logic [31:0] d;
      op = $urandom_range(0, 4);
      c  = $urandom_range(0, 3);
      d  = $urandom;
      case (op)
        0: begin
          bus_write(16'h0048 + 16'(c * 16), d, 1'b0);
          ref_m[c] = d;
          for (int n = 0; n < 4; n++)
            chk($sformatf("rnd_ref_port%0d", n), ref_len[n*32 +: 32], ref_m[n]);
        end
        1: begin
          bus_write(16'h0008, d, 1'b0);
          irq_en_m = d[3:0];
          read_chk("rnd_irq_en", 16'h0008, {28'd0, irq_en_m}, 1'b0);
        end
        2: read_chk($sformatf("rnd_ref_rd%0d", c), 16'h0048 + 16'(c * 16), ref_m[c], 1'b0);
        3: read_chk("rnd_invalid", 16'h0080 + 16'($urandom_range(0, 15) * 4), 32'h0, 1'b1);
        default: begin
          int len;
          len = $urandom_range(1, 20);
          bus_write(16'h0050, 32'h2, 1'b0);
          core_busy[1] = 1'b1;
          repeat (len) @(posedge clk);
          #1 core_busy[1] = 1'b0;
          repeat (2) @(posedge clk);
          #1 chk("rnd_run_idle", 32'(core_rs[1]), 0);
          read_chk($sformatf("rnd_cycles_len%0d", len), 16'h005C, 32'(len), 1'b0);
        end
      endcase
    end

    // Reset in the middle of a run
    bus_write(16'h000C, 32'hF, 1'b0);
    bus_write(16'h0040, 32'h2, 1'b0);
    core_busy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rs", 32'(core_rs), 0);
    rst = 1'b0; core_busy[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid_rst_irq", 32'(irq), 0);
    read_chk("mid_rst_irq_status", 16'h000C, 32'h0, 1'b0);
    read_chk("mid_rst_ref1", 16'h0058, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
